// File: rtl/mask_encoder32to5.sv
// mask_encoder32to5: sequential priority encoder over a multi-hot mask.
// Captures a WIDTH-bit mask on LOAD while idle and emits the index of
// each set bit, lowest first, one per OUT_VALID/OUT_READY transfer.
// DONE pulses for one cycle after the last index is taken, or after a
// LOAD of an all-zero mask.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous reset, active-high
//   LOAD       capture MASK (ignored while BUSY)
//   MASK       multi-hot mask to encode
//   BUSY       high while emitting
//   OUT_VALID  OUT holds a valid index
//   OUT_READY  consumer accepts OUT this cycle
//   OUT        lowest pending index (0 when idle)
//   COUNT      number of pending set bits
//   DONE       one-cycle completion pulse
module mask_encoder32to5 #(
    parameter int unsigned WIDTH = 32,  // must equal 2**IDX_W
    parameter int unsigned IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] MASK,
    output logic             BUSY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [IDX_W-1:0] OUT,
    output logic [IDX_W:0]   COUNT,
    output logic             DONE
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   pending;
    logic [WIDTH-1:0]   pending_next;
    logic               done_next;
    logic [IDX_W-1:0]   low_idx;
    logic [CNT_W-1:0]   pop_cnt;

    // Lowest set bit of pending; scanning downward lets the lowest hit win.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Popcount of pending.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + CNT_W'(pending[i]);
        end
    end

    // Next-state, pending update and completion pulse.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        done_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (LOAD) begin
                    if (MASK != '0) begin
                        pending_next = MASK;
                        state_next   = ST_EMIT;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (OUT_READY) begin
                    pending_next[low_idx] = 1'b0;
                    if (pop_cnt == CNT_W'(1)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                pending_next = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            pending <= '0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            DONE    <= done_next;
        end
    end

    // Outputs decoded from registered state; pending is zero whenever idle.
    assign BUSY      = (state == ST_EMIT);
    assign OUT_VALID = BUSY;
    assign OUT       = BUSY ? low_idx : '0;
    assign COUNT     = pop_cnt;

endmodule

// File: tb/tb_mask_encoder32to5.sv
// tb_mask_encoder32to5: directed bench with an index scoreboard.
// Expected indices are queued from each accepted mask and popped as
// transfers happen; outputs are sampled 1 ns after the rising edge.
module tb_mask_encoder32to5;

    logic        CLK;
    logic        RST;
    logic        LOAD;
    logic [31:0] MASK;
    logic        BUSY;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [4:0]  OUT;
    logic [5:0]  COUNT;
    logic        DONE;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned exp_q[$];

    mask_encoder32to5 #(.WIDTH(32), .IDX_W(5)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .LOAD      (LOAD),
        .MASK      (MASK),
        .BUSY      (BUSY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (OUT),
        .COUNT     (COUNT),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue the indices a mask should produce, lowest first.
    task automatic push_mask(input logic [31:0] m);
        for (int i = 0; i < 32; i++) begin
            if (m[i]) exp_q.push_back(i);
        end
    endtask

    // Accept a mask from IDLE.
    task automatic do_load(input logic [31:0] m);
        LOAD = 1'b1;
        MASK = m;
        tick();
        LOAD = 1'b0;
        MASK = '0;
        push_mask(m);
    endtask

    // Compare one cycle against the scoreboard, then advance the clock.
    task automatic emit_cycle(input logic rdy);
        OUT_READY = rdy;
        check("valid", 32'(OUT_VALID), 32'(exp_q.size() != 0));
        check("busy", 32'(BUSY), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("out", 32'(OUT), exp_q[0]);
            check("count", 32'(COUNT), 32'(exp_q.size()));
            if (rdy) void'(exp_q.pop_front());
        end
        tick();
    endtask

    // Drain with ready high, then check the DONE pulse and its end.
    task automatic drain_and_done(input string tag);
        int unsigned budget;
        budget = 40;
        while (exp_q.size() != 0 && budget != 0) begin
            emit_cycle(1'b1);
            budget--;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({tag, "_done"}, 32'(DONE), 32'd1);
        check({tag, "_valid_off"}, 32'(OUT_VALID), 32'd0);
        check({tag, "_busy_off"}, 32'(BUSY), 32'd0);
        OUT_READY = 1'b0;
        tick();
        check({tag, "_done_1cyc"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        RST       = 1'b1;
        LOAD      = 1'b1;
        MASK      = 32'h5;
        OUT_READY = 1'b1;

        // Reset overrides a LOAD held alongside it.
        tick();
        tick();
        RST  = 1'b0;
        LOAD = 1'b0;
        MASK = '0;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out", 32'(OUT), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);

        // OUT_READY in IDLE is ignored.
        OUT_READY = 1'b1;
        tick();
        check("idle_ready_valid", 32'(OUT_VALID), 32'd0);
        check("idle_ready_done", 32'(DONE), 32'd0);

        // Single bit.
        do_load(32'h0000_0001);
        drain_and_done("single");

        // Three bits spread across the word.
        do_load(32'h8000_0011);
        drain_and_done("spread");

        // Back-pressure holds OUT and COUNT.
        do_load(32'h0000_0006);
        emit_cycle(1'b0);
        emit_cycle(1'b0);
        emit_cycle(1'b0);
        drain_and_done("stall");

        // Empty mask: DONE without ever going valid.
        LOAD = 1'b1;
        MASK = 32'h0;
        tick();
        LOAD = 1'b0;
        check("zero_done", 32'(DONE), 32'd1);
        check("zero_valid", 32'(OUT_VALID), 32'd0);
        check("zero_busy", 32'(BUSY), 32'd0);
        tick();
        check("zero_done_1cyc", 32'(DONE), 32'd0);
        check("zero_valid2", 32'(OUT_VALID), 32'd0);

        // LOAD while busy, including on the final transfer, is dropped.
        do_load(32'h0000_0300);
        LOAD = 1'b1;
        MASK = 32'h0000_0001;
        emit_cycle(1'b1);
        emit_cycle(1'b1);
        LOAD = 1'b0;
        MASK = '0;
        check("busyload_done", 32'(DONE), 32'd1);
        check("busyload_valid", 32'(OUT_VALID), 32'd0);

        // LOAD in the DONE cycle is accepted.
        do_load(32'h0000_0C00);
        drain_and_done("load_on_done");

        // All ones, aborted by reset after five transfers.
        do_load(32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) emit_cycle(1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_q.delete();
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_valid", 32'(OUT_VALID), 32'd0);
        check("abort_count", 32'(COUNT), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        tick();
        check("abort_done2", 32'(DONE), 32'd0);
        check("abort_valid2", 32'(OUT_VALID), 32'd0);

        // All ones to completion: 32 transfers, COUNT 32 down to 1.
        do_load(32'hFFFF_FFFF);
        drain_and_done("full");

        // Random masks with random back-pressure.
        for (int t = 0; t < 6; t++) begin
            logic [31:0] m;
            int unsigned budget;
            m = $urandom();
            if (m == 0) m = 32'h1;
            do_load(m);
            budget = 200;
            while (exp_q.size() > 1 && budget != 0) begin
                emit_cycle(1'($urandom_range(0, 1)));
                budget--;
            end
            drain_and_done("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mask_encoder32to5.md
Name: mask_encoder32to5

Overview:
Sequential priority encoder, the inverse of the datapath 5-to-32 decoder. It captures a 32-bit multi-hot mask, for example a register-select set for a store-multiple or a context-save sequence. It then emits the 5-bit index of each set bit, lowest index first, one index per valid/ready handshake. It sits in the datapath between control logic that builds register masks and the register-file address ports.

Parameters:
WIDTH, 32, mask width; must equal 2**IDX_W
IDX_W, 5, width of the emitted index

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous reset, active-high
LOAD  input  1  capture MASK; honoured only when BUSY=0
MASK  input  WIDTH  multi-hot mask to encode
BUSY  output  1  high while in state EMIT
OUT_VALID  output  1  OUT holds a valid index
OUT_READY  input  1  consumer accepts OUT this cycle
OUT  output  IDX_W  index of the lowest set bit still pending
COUNT  output  IDX_W+1  number of set bits still pending (popcount of the pending register)
DONE  output  1  single-cycle pulse when a sequence completes

Behaviour:
- Interface: one clock, CLK. Reset is RST, synchronous and active-high.
- Reset:
  - state=IDLE and the pending register is 0.
  - BUSY=0, OUT_VALID=0, OUT=0, COUNT=0, DONE=0.
  - These values are visible the cycle after RST is sampled high.
  - RST overrides LOAD and handshakes.
- States: IDLE and EMIT.
- IDLE:
  - BUSY=0, OUT_VALID=0, OUT=0.
  - LOAD=1 with MASK!=0: next cycle pending=MASK and state=EMIT.
  - LOAD=1 with MASK==0: stay in IDLE; DONE=1 in the next cycle; OUT_VALID is never raised.
- EMIT:
  - BUSY=1 and OUT_VALID=1.
  - OUT = index of the lowest set bit of pending, combinational from the pending register. It is valid in the first EMIT cycle, so there is no bubble.
  - COUNT = popcount(pending).
- Handshake:
  - A transfer happens when OUT_VALID & OUT_READY at the rising edge.
  - On a transfer, bit OUT of pending is cleared.
  - Throughput is one index per cycle while OUT_READY is held high.
  - While OUT_VALID=1 and OUT_READY=0, OUT and COUNT stay stable.
- Completion:
  - When the transfer consumes the last pending bit (COUNT==1), the next cycle has state=IDLE, BUSY=0, OUT_VALID=0, and DONE=1 for exactly one cycle.
- DONE is registered and high only in the cycle after completion.
- Latency: from LOAD accepted to the first OUT_VALID is 1 cycle. From the final transfer to DONE is 1 cycle.
- Boundary conditions:
  - LOAD while BUSY=1, including in the cycle of the final transfer, is ignored and the mask is dropped.
  - LOAD in the cycle DONE=1 is accepted, since the state is IDLE.
  - MASK=0xFFFFFFFF emits indices 0..31 in order: 32 transfers, COUNT running 32 down to 1.
  - RST during EMIT aborts the sequence: pending is cleared, no DONE pulse, IDLE next cycle.
  - OUT_READY in IDLE is ignored.

Test Plan:
- Reset, then LOAD MASK=0x00000001 with OUT_READY=1 -> next cycle OUT_VALID=1, OUT=0, COUNT=1. The following cycle OUT_VALID=0 and DONE=1 for one cycle.
- LOAD MASK=0x80000011 with OUT_READY=1 -> OUT is 0, 4, 31 on three consecutive cycles and COUNT is 3, 2, 1. DONE=1 on the fourth cycle.
- MASK=0x00000006 with OUT_READY=0 for 3 cycles, then 1 -> OUT holds 1 and COUNT holds 2 for 3 cycles. Then OUT=2, then DONE.
- LOAD MASK=0 -> DONE=1 next cycle, OUT_VALID stays 0, BUSY stays 0.
- While emitting MASK=0x00000300, pulse LOAD with MASK=0x00000001 -> ignored; only indices 8 and 9 are emitted.
- MASK=0xFFFFFFFF, assert RST after 5 transfers -> next cycle BUSY=0, OUT_VALID=0, COUNT=0, and DONE never pulses.
